dram_device_model: RTL and testbench

Cycle-accurate, synthesizable responder model of the DRAM device that dram_controller drives. It decodes cs_n/ras_n/cas_n/we_n commands and tracks one open row per bank. It holds a bank×row×column storage array, returns read data and runs timed refresh with a one-cycle dram_refresh_done pulse. It is the bench/FPGA-side partner of the controller; status outputs exist for verification visibility.

---
 rtl/dram_device_model_if.sv | 59 +++++
 rtl/dram_device_model.sv | 176 +++++++++++++++++
 tb/tb_dram_device_model.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/dram_device_model_if.sv
`default_nettype none
// ============================================================================
//  Module   : dram_device_model_if
//  Purpose  : Command/data bundle between a DRAM controller (master) and the
//             DRAM device model (slave).
//  Signals  :
//    dram_clk_en        master->slave  command/clock enable (0 = freeze)
//    dram_cs_n          master->slave  chip select, active low
//    dram_ras_n/cas_n/we_n master->slave command code
//    dram_bank_id       master->slave  target bank
//    dram_addr          master->slave  row (ACTIVATE) or column (READ/WRITE)
//    dram_wr_data       master->slave  write data
//    dram_rd_data       slave->master  registered read data
//    dram_refresh_done  slave->master  one-cycle refresh completion pulse
//    dev_open_banks     slave->master  per-bank open-row flags
//    dev_refresh_busy   slave->master  refresh in progress
//    dev_cmd_err        slave->master  sticky protocol-error flag
//  Revision : 1.0  initial release
// ============================================================================
interface dram_device_model_if #(
  parameter int NUMBER_OF_COLUMNS = 8,
  parameter int NUMBER_OF_ROWS    = 128,
  parameter int NUMBER_OF_BANKS   = 8,
  parameter int DRAM_DATA_WIDTH   = 8
);
  localparam int COLUMN_WIDTH    = $clog2(NUMBER_OF_COLUMNS);
  localparam int ROW_WIDTH       = $clog2(NUMBER_OF_ROWS);
  localparam int BANK_ID_WIDTH   = $clog2(NUMBER_OF_BANKS);
  localparam int DRAM_ADDR_WIDTH = (ROW_WIDTH > COLUMN_WIDTH) ? ROW_WIDTH : COLUMN_WIDTH;

  logic                       dram_clk_en;
  logic                       dram_cs_n;
  logic                       dram_ras_n;
  logic                       dram_cas_n;
  logic                       dram_we_n;
  logic [BANK_ID_WIDTH-1:0]   dram_bank_id;
  logic [DRAM_ADDR_WIDTH-1:0] dram_addr;
  logic [DRAM_DATA_WIDTH-1:0] dram_wr_data;
  logic [DRAM_DATA_WIDTH-1:0] dram_rd_data;
  logic                       dram_refresh_done;
  logic [NUMBER_OF_BANKS-1:0] dev_open_banks;
  logic                       dev_refresh_busy;
  logic                       dev_cmd_err;

  modport master (
    output dram_clk_en, dram_cs_n, dram_ras_n, dram_cas_n, dram_we_n,
           dram_bank_id, dram_addr, dram_wr_data,
    input  dram_rd_data, dram_refresh_done, dev_open_banks,
           dev_refresh_busy, dev_cmd_err
  );

  modport slave (
    input  dram_clk_en, dram_cs_n, dram_ras_n, dram_cas_n, dram_we_n,
           dram_bank_id, dram_addr, dram_wr_data,
    output dram_rd_data, dram_refresh_done, dev_open_banks,
           dev_refresh_busy, dev_cmd_err
  );
endinterface
`default_nettype wire

// File: rtl/dram_device_model.sv
`default_nettype none
// ============================================================================
//  Module   : dram_device_model
//  Purpose  : Cycle-accurate responder model of a DRAM device. Decodes
//             cs_n/ras_n/cas_n/we_n commands, tracks one open row per bank,
//             stores data in a bank x row x column array, returns registered
//             read data and runs a timed refresh ending in a one-cycle
//             dram_refresh_done pulse.
//  Ports    :
//    u_clk  in   clock, all state changes on the rising edge
//    u_rst  in   asynchronous active-high reset
//    bus    slave modport of dram_device_model_if (commands in, data/status out)
//  Revision : 1.0  initial release
// ============================================================================
module dram_device_model #(
  parameter int NUMBER_OF_COLUMNS = 8,
  parameter int NUMBER_OF_ROWS    = 128,
  parameter int NUMBER_OF_BANKS   = 8,
  parameter int DRAM_DATA_WIDTH   = 8,
  parameter int REFRESH_CYCLES    = 4
) (
  input  wire logic             u_clk,
  input  wire logic             u_rst,
  dram_device_model_if.slave    bus
);
  localparam int COLUMN_WIDTH    = $clog2(NUMBER_OF_COLUMNS);
  localparam int ROW_WIDTH       = $clog2(NUMBER_OF_ROWS);
  localparam int BANK_ID_WIDTH   = $clog2(NUMBER_OF_BANKS);
  localparam int MEM_ADDR_WIDTH  = BANK_ID_WIDTH + ROW_WIDTH + COLUMN_WIDTH;
  localparam int MEM_DEPTH       = 1 << MEM_ADDR_WIDTH;
  localparam int CNT_WIDTH       = $clog2(REFRESH_CYCLES + 1);

  // {ras_n, cas_n, we_n} command codes
  localparam logic [2:0] c_CMD_ACTIVATE  = 3'b011;
  localparam logic [2:0] c_CMD_PRECHARGE = 3'b010;
  localparam logic [2:0] c_CMD_WRITE     = 3'b100;
  localparam logic [2:0] c_CMD_READ      = 3'b101;
  localparam logic [2:0] c_CMD_REFRESH   = 3'b001;
  localparam logic [2:0] c_CMD_NOP       = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                     r_state;
  logic [CNT_WIDTH-1:0]       r_cnt;
  logic                       r_busy;
  logic                       r_done;
  logic [NUMBER_OF_BANKS-1:0] r_open_banks;
  logic [ROW_WIDTH-1:0]       r_active_row [NUMBER_OF_BANKS];
  logic [DRAM_DATA_WIDTH-1:0] r_rd_data;
  logic                       r_cmd_err;
  logic [DRAM_DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  logic                       w_cmd_valid;
  logic [2:0]                 w_cmd;
  logic [BANK_ID_WIDTH-1:0]   w_bank;
  logic [ROW_WIDTH-1:0]       w_row;
  logic [COLUMN_WIDTH-1:0]    w_col;
  logic                       w_bank_open;
  logic                       w_in_refresh;
  logic [MEM_ADDR_WIDTH-1:0]  w_mem_idx;
  logic                       w_wr_en;
  logic                       w_rd_en;
  logic                       w_cmd_err;

  assign w_cmd_valid  = bus.dram_clk_en & ~bus.dram_cs_n;
  assign w_cmd        = {bus.dram_ras_n, bus.dram_cas_n, bus.dram_we_n};
  assign w_bank       = bus.dram_bank_id;
  assign w_row        = bus.dram_addr[ROW_WIDTH-1:0];
  // Upper address bits are don't-care for column accesses
  assign w_col        = bus.dram_addr[COLUMN_WIDTH-1:0];
  assign w_bank_open  = r_open_banks[w_bank];
  // The DONE cycle counts as part of refresh for command legality
  assign w_in_refresh = (r_state != S_IDLE);
  assign w_mem_idx    = {w_bank, r_active_row[w_bank], w_col};

  assign w_wr_en = w_cmd_valid && (w_cmd == c_CMD_WRITE) && !w_in_refresh && w_bank_open;
  assign w_rd_en = w_cmd_valid && (w_cmd == c_CMD_READ)  && !w_in_refresh && w_bank_open;

  always_comb begin
    w_cmd_err = 1'b0;
    if (w_cmd_valid) begin
      case (w_cmd)
        c_CMD_NOP,
        c_CMD_REFRESH:   w_cmd_err = 1'b0;
        // Re-activating an open bank is flagged but still honoured below
        c_CMD_ACTIVATE:  w_cmd_err = w_in_refresh || w_bank_open;
        c_CMD_PRECHARGE: w_cmd_err = w_in_refresh;
        c_CMD_READ,
        c_CMD_WRITE:     w_cmd_err = w_in_refresh || !w_bank_open;
        default:         w_cmd_err = 1'b1;
      endcase
    end
  end

  // Storage array is deliberately not reset
  always_ff @(posedge u_clk) begin
    if (w_wr_en) begin
      r_mem[w_mem_idx] <= bus.dram_wr_data;
    end
  end

  always_ff @(posedge u_clk or posedge u_rst) begin
    if (u_rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_open_banks <= '0;
      for (int b = 0; b < NUMBER_OF_BANKS; b++) begin
        r_active_row[b] <= '0;
      end
      r_rd_data    <= '0;
      r_cmd_err    <= 1'b0;
    end else begin
      if (w_cmd_err) begin
        r_cmd_err <= 1'b1;
      end
      if (w_rd_en) begin
        r_rd_data <= r_mem[w_mem_idx];
      end

      case (r_state)
        S_IDLE: begin
          if (w_cmd_valid) begin
            if (w_cmd == c_CMD_REFRESH) begin
              // Implicit precharge-all on refresh entry
              r_state      <= S_BUSY;
              r_busy       <= 1'b1;
              r_cnt        <= CNT_WIDTH'(REFRESH_CYCLES - 1);
              r_open_banks <= '0;
            end else if (w_cmd == c_CMD_ACTIVATE) begin
              r_open_banks[w_bank] <= 1'b1;
              r_active_row[w_bank] <= w_row;
            end else if (w_cmd == c_CMD_PRECHARGE) begin
              r_open_banks[w_bank] <= 1'b0;
            end
          end
        end
        S_BUSY: begin
          // Counter only advances on enabled edges, so clk_en=0 stretches refresh
          if (bus.dram_clk_en) begin
            if (r_cnt == '0) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
        end
        S_DONE: begin
          // Done is a single-cycle pulse; a REFRESH seen here is absorbed
          r_state <= S_IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.dram_rd_data      = r_rd_data;
  assign bus.dram_refresh_done = r_done;
  assign bus.dev_open_banks    = r_open_banks;
  assign bus.dev_refresh_busy  = r_busy;
  assign bus.dev_cmd_err       = r_cmd_err;

endmodule
`default_nettype wire

// File: tb/tb_dram_device_model.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dram_device_model
//  Purpose  : Directed self-checking bench for dram_device_model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dram_device_model;
  localparam logic [2:0] C_ACT = 3'b011;
  localparam logic [2:0] C_PRE = 3'b010;
  localparam logic [2:0] C_WR  = 3'b100;
  localparam logic [2:0] C_RD  = 3'b101;
  localparam logic [2:0] C_REF = 3'b001;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  dram_device_model_if #(
    .NUMBER_OF_COLUMNS(8), .NUMBER_OF_ROWS(128),
    .NUMBER_OF_BANKS(8), .DRAM_DATA_WIDTH(8)
  ) bus ();

  dram_device_model #(
    .NUMBER_OF_COLUMNS(8), .NUMBER_OF_ROWS(128), .NUMBER_OF_BANKS(8),
    .DRAM_DATA_WIDTH(8), .REFRESH_CYCLES(4)
  ) dut (
    .u_clk (clk),
    .u_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_bus();
    bus.dram_cs_n  = 1'b1;
    bus.dram_ras_n = 1'b1;
    bus.dram_cas_n = 1'b1;
    bus.dram_we_n  = 1'b1;
  endtask

  task automatic drive(input logic [2:0] c, input logic [2:0] b, input logic [6:0] a, input logic [7:0] d);
    bus.dram_cs_n = 1'b0;
    {bus.dram_ras_n, bus.dram_cas_n, bus.dram_we_n} = c;
    bus.dram_bank_id = b;
    bus.dram_addr    = a;
    bus.dram_wr_data = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic [2:0] c, input logic [2:0] b, input logic [6:0] a, input logic [7:0] d);
    drive(c, b, a, d);
    tick();
    idle_bus();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    bus.dram_clk_en = 1'b1;
    bus.dram_bank_id = '0;
    bus.dram_addr = '0;
    bus.dram_wr_data = '0;
    idle_bus();
    do_reset();
    checks++; if (bus.dram_rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data: got %h expected 00", bus.dram_rd_data); end
    checks++; if (bus.dram_refresh_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.dram_refresh_done); end
    checks++; if (bus.dev_open_banks !== 8'h00) begin errors++; $display("FAIL reset_open: got %h expected 00", bus.dev_open_banks); end
    checks++; if (bus.dev_refresh_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.dev_refresh_busy); end
    checks++; if (bus.dev_cmd_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", bus.dev_cmd_err); end
  endtask

  task automatic test_basic_rw();
    cmd(C_ACT, 3'd3, 7'h25, 8'h00);
    cmd(C_WR,  3'd3, 7'h05, 8'hA5);
    cmd(C_RD,  3'd3, 7'h05, 8'h00);
    checks++; if (bus.dram_rd_data !== 8'hA5) begin errors++; $display("FAIL rw_rd_data: got %h expected a5", bus.dram_rd_data); end
    checks++; if (bus.dev_open_banks !== 8'h08) begin errors++; $display("FAIL rw_open: got %h expected 08", bus.dev_open_banks); end
    checks++; if (bus.dev_cmd_err !== 1'b0) begin errors++; $display("FAIL rw_err: got %b expected 0", bus.dev_cmd_err); end
  endtask

  task automatic test_row_isolation();
    cmd(C_PRE, 3'd3, 7'h00, 8'h00);
    checks++; if (bus.dev_open_banks !== 8'h00) begin errors++; $display("FAIL iso_pre_open: got %h expected 00", bus.dev_open_banks); end
    cmd(C_ACT, 3'd3, 7'h26, 8'h00);
    cmd(C_WR,  3'd3, 7'h05, 8'h3C);
    cmd(C_PRE, 3'd3, 7'h00, 8'h00);
    cmd(C_ACT, 3'd3, 7'h25, 8'h00);
    cmd(C_RD,  3'd3, 7'h05, 8'h00);
    checks++; if (bus.dram_rd_data !== 8'hA5) begin errors++; $display("FAIL iso_row25: got %h expected a5", bus.dram_rd_data); end
    // Held value while NOPs follow
    tick();
    checks++; if (bus.dram_rd_data !== 8'hA5) begin errors++; $display("FAIL iso_hold: got %h expected a5", bus.dram_rd_data); end
    cmd(C_PRE, 3'd3, 7'h00, 8'h00);
    cmd(C_ACT, 3'd3, 7'h26, 8'h00);
    // Column 5 addressed with upper bits set: 0x0D -> col 5
    cmd(C_RD,  3'd3, 7'h0D, 8'h00);
    checks++; if (bus.dram_rd_data !== 8'h3C) begin errors++; $display("FAIL iso_row26: got %h expected 3c", bus.dram_rd_data); end
    checks++; if (bus.dev_cmd_err !== 1'b0) begin errors++; $display("FAIL iso_err: got %b expected 0", bus.dev_cmd_err); end
  endtask

  task automatic test_refresh();
    int done_at;
    int pulses;
    cmd(C_ACT, 3'd6, 7'h01, 8'h00);
    checks++; if (bus.dev_open_banks !== 8'h48) begin errors++; $display("FAIL ref_pre_open: got %h expected 48", bus.dev_open_banks); end
    drive(C_REF, 3'd0, 7'h00, 8'h00);
    tick(); // edge T0
    checks++; if (bus.dev_refresh_busy !== 1'b1) begin errors++; $display("FAIL ref_busy_t0: got %b expected 1", bus.dev_refresh_busy); end
    checks++; if (bus.dev_open_banks !== 8'h00) begin errors++; $display("FAIL ref_open: got %h expected 00", bus.dev_open_banks); end
    done_at = -1;
    pulses  = 0;
    for (int k = 1; k <= 16; k++) begin
      if (k >= 6) idle_bus(); // REFRESH still held through the done cycle
      tick();
      if (bus.dram_refresh_done === 1'b1) begin
        pulses++;
        if (done_at < 0) done_at = k;
      end
      if (k == 3) begin
        checks++; if (bus.dev_refresh_busy !== 1'b1) begin errors++; $display("FAIL ref_busy_t3: got %b expected 1", bus.dev_refresh_busy); end
      end
      if (k == 4) begin
        checks++; if (bus.dev_refresh_busy !== 1'b0) begin errors++; $display("FAIL ref_busy_done: got %b expected 0", bus.dev_refresh_busy); end
      end
    end
    checks++; if (done_at !== 4) begin errors++; $display("FAIL ref_done_cycle: got %0d expected 4", done_at); end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL ref_done_pulses: got %0d expected 1", pulses); end
    checks++; if (bus.dev_cmd_err !== 1'b0) begin errors++; $display("FAIL ref_err: got %b expected 0", bus.dev_cmd_err); end
  endtask

  task automatic test_errors();
    cmd(C_RD, 3'd2, 7'h01, 8'h00);
    checks++; if (bus.dev_cmd_err !== 1'b1) begin errors++; $display("FAIL err_closed_read: got %b expected 1", bus.dev_cmd_err); end
    checks++; if (bus.dram_rd_data !== 8'h3C) begin errors++; $display("FAIL err_rd_unchanged: got %h expected 3c", bus.dram_rd_data); end
    do_reset();
    checks++; if (bus.dev_cmd_err !== 1'b0) begin errors++; $display("FAIL err_cleared: got %b expected 0", bus.dev_cmd_err); end
    cmd(C_REF, 3'd0, 7'h00, 8'h00);
    cmd(C_ACT, 3'd1, 7'h05, 8'h00);
    checks++; if (bus.dev_cmd_err !== 1'b1) begin errors++; $display("FAIL err_act_busy: got %b expected 1", bus.dev_cmd_err); end
    checks++; if (bus.dev_open_banks !== 8'h00) begin errors++; $display("FAIL err_act_busy_open: got %h expected 00", bus.dev_open_banks); end
    repeat (8) tick();
  endtask

  task automatic test_clk_en();
    int done_at;
    int pulses;
    do_reset();
    cmd(C_REF, 3'd0, 7'h00, 8'h00); // edge T0
    done_at = -1;
    pulses  = 0;
    for (int k = 1; k <= 12; k++) begin
      bus.dram_clk_en = (k >= 2 && k <= 4) ? 1'b0 : 1'b1;
      tick();
      if (bus.dram_refresh_done === 1'b1) begin
        pulses++;
        if (done_at < 0) done_at = k;
      end
    end
    bus.dram_clk_en = 1'b1;
    checks++; if (done_at !== 7) begin errors++; $display("FAIL clken_done_cycle: got %0d expected 7", done_at); end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL clken_pulses: got %0d expected 1", pulses); end
    cmd(C_ACT, 3'd0, 7'h02, 8'h00);
    cmd(C_WR,  3'd0, 7'h01, 8'h11);
    bus.dram_clk_en = 1'b0;
    cmd(C_WR,  3'd0, 7'h01, 8'h77);
    bus.dram_clk_en = 1'b1;
    cmd(C_RD,  3'd0, 7'h01, 8'h00);
    checks++; if (bus.dram_rd_data !== 8'h11) begin errors++; $display("FAIL clken_write_frozen: got %h expected 11", bus.dram_rd_data); end
    checks++; if (bus.dev_cmd_err !== 1'b0) begin errors++; $display("FAIL clken_err: got %b expected 0", bus.dev_cmd_err); end
  endtask

  task automatic test_reset_mid_refresh();
    int pulses;
    cmd(C_RD, 3'd7, 7'h00, 8'h00);
    checks++; if (bus.dev_cmd_err !== 1'b1) begin errors++; $display("FAIL mid_pre_err: got %b expected 1", bus.dev_cmd_err); end
    cmd(C_ACT, 3'd4, 7'h09, 8'h00);
    cmd(C_REF, 3'd0, 7'h00, 8'h00);
    tick();
    tick();
    checks++; if (bus.dev_refresh_busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before: got %b expected 1", bus.dev_refresh_busy); end
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.dev_refresh_busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b expected 0", bus.dev_refresh_busy); end
    checks++; if (bus.dev_open_banks !== 8'h00) begin errors++; $display("FAIL mid_open: got %h expected 00", bus.dev_open_banks); end
    checks++; if (bus.dev_cmd_err !== 1'b0) begin errors++; $display("FAIL mid_err: got %b expected 0", bus.dev_cmd_err); end
    checks++; if (bus.dram_rd_data !== 8'h00) begin errors++; $display("FAIL mid_rd_data: got %h expected 00", bus.dram_rd_data); end
    tick();
    tick();
    rst = 1'b0;
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (bus.dram_refresh_done === 1'b1) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL mid_no_done: got %0d expected 0", pulses); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b1;
    test_reset();
    test_basic_rw();
    test_row_isolation();
    test_refresh();
    test_errors();
    test_clk_en();
    test_reset_mid_refresh();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
